i2c_bus_arbiter: RTL
====================

Name: i2c_bus_arbiter

Overview:
Shares the single I2C master between independent requesters: the ALS sensor reader, display panel configuration and the calibration EEPROM loader. Each request is one complete single-register transaction. The block grants requests round-robin, drives the master's command interface, routes completion, read data and error status back to the winner, and aborts hung transactions with a timeout. It sits between the requesting blocks and the I2C master, beneath the top-level control sequencer.

Parameters:
N_REQ, 3, number of requesters (index 0 = ALS, 1 = display, 2 = EEPROM)
TIMEOUT_CYCLES, 2500000, cycles allowed from m_start to m_done (50 ms @ 50 MHz)
TO_W, 22, timeout counter width (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req  in  N_REQ  per-requester transaction request level
req_dev_addr  in  7*N_REQ  per-requester 7-bit device address, requester i at bits [7i+6:7i]
req_reg_addr  in  8*N_REQ  per-requester register address
req_rw  in  N_REQ  1 = read, 0 = write
req_wdata  in  8*N_REQ  per-requester write data
grant  out  N_REQ  one-hot; marks the current owner for the whole transaction
done  out  N_REQ  one-cycle completion pulse to the owner
rdata  out  8  read data, valid while done is asserted
err  out  1  valid while done is asserted: 1 = NACK or timeout
m_start  out  1  one-cycle command strobe to the master
m_dev_addr  out  7  latched device address
m_reg_addr  out  8  latched register address
m_rw  out  1  latched direction
m_wdata  out  8  latched write data
m_abort  out  1  one-cycle abort strobe to the master on timeout
m_busy  in  1  master busy
m_done  in  1  master completion pulse
m_ack_err  in  1  NACK flag, valid with m_done
m_rdata  in  8  master read data, valid with m_done
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE. grant, done, err, m_start, m_abort, busy and rdata are all 0. All m_* command fields are 0. The round-robin pointer is 0 and the timeout counter is 0.
- All outputs are registered. There is no combinational path from any input to any output.
- State IDLE: if any req bit is set, select the first requester at or after the pointer, searching upward with wrap-around.
  - Latch that requester's command fields into the m_* outputs.
  - Set grant to the winner's one-hot value and go to ISSUE.
  - grant rises on the cycle after req is sampled.
- State ISSUE: assert m_start for exactly one cycle, load the timeout counter with 0, go to WAIT_DONE.
- State WAIT_DONE: the counter increments every cycle.
  - m_done seen: capture m_rdata into rdata and m_ack_err into err, go to COMPLETE.
  - Counter reaches TIMEOUT_CYCLES-1 without m_done: pulse m_abort for one cycle, set err=1, set rdata=0, go to COMPLETE.
  - m_done and timeout in the same cycle: m_done wins and there is no abort.
- State COMPLETE: pulse done[owner] for one cycle with rdata and err held valid.
  - Advance the pointer to owner+1, wrapping at N_REQ.
  - Clear grant and return to IDLE on the next cycle.
  - Minimum gap between back-to-back grants is one IDLE cycle.
- Command fields are latched at grant. Requester inputs may change after that with no effect on the transaction in flight.
- Requester handshake: a requester holds req high until it sees done, then drops it.
  - If req drops mid-transaction, the transaction still completes and done is still pulsed.
  - If req is still high on the IDLE cycle after done, it is treated as a new request and competes normally.
- m_busy is used for status only. If m_done arrives while the state is IDLE or ISSUE, it is ignored.
- Fairness: a requester that is continuously asserted waits at most N_REQ-1 other transactions before it is granted.
- grant is always one-hot or zero. done is only ever asserted on the bit that is set in grant.

Test Plan:
- Single read: req=001, dev=0x29, reg=0x14, rw=1; master returns m_rdata=0xA5 three cycles after m_start.
  -> grant=001 one cycle after req; m_start pulses once with dev=0x29, reg=0x14; done[0] pulses with rdata=0xA5, err=0.
- All three requesting continuously, pointer=0.
  -> grant order 001, 010, 100, 001; exactly one done per grant; each grant separated by at least one IDLE cycle.
- NACK: requester 1 writes 0x3C to reg 0x02; m_done arrives with m_ack_err=1.
  -> done[1] pulses with err=1; the pointer advances to 2.
- Timeout: TIMEOUT_CYCLES=16 and m_done is never asserted.
  -> m_abort pulses exactly 16 cycles after m_start; done[owner] pulses with err=1 and rdata=0; the state returns to IDLE.
- Requester 2 drops req two cycles after grant.
  -> the transaction completes; done[2] still pulses; no new grant is given to 2.
- rst asserted while in WAIT_DONE.
  -> all outputs go to 0 immediately (asynchronously); after rst is released with req=010, grant=010 is given on the first eligible cycle.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter
//
// Shares one I2C master between N_REQ independent requesters (0 = ALS sensor
// reader, 1 = display configuration, 2 = calibration EEPROM loader). Each
// request is one complete single-register transaction. Requests are granted
// round-robin. The winner's command fields are latched and presented to the
// master. Completion, read data and error status are routed back to the
// winner. A transaction that never completes is aborted after TIMEOUT_CYCLES.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   req               per-requester request level
//   req_dev_addr      7-bit device address per requester (requester i at [7i+6:7i])
//   req_reg_addr      8-bit register address per requester
//   req_rw            per-requester direction, 1 = read
//   req_wdata         8-bit write data per requester
//   grant             one-hot owner of the transaction in flight
//   done              one-cycle completion pulse on the owner's bit
//   rdata, err        read data and NACK/timeout flag, valid with done
//   m_start           one-cycle command strobe to the master
//   m_dev_addr, m_reg_addr, m_rw, m_wdata
//                     latched command fields to the master
//   m_abort           one-cycle abort strobe to the master on timeout
//   m_busy            master busy (status only, not used for sequencing)
//   m_done            master completion pulse
//   m_ack_err         master NACK flag, valid with m_done
//   m_rdata           master read data, valid with m_done
//   busy              high whenever the arbiter is not idle
//
// Every output comes straight from a flop; there is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module i2c_bus_arbiter #(
    parameter int N_REQ          = 3,
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int TO_W           = 22
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [7*N_REQ-1:0]   req_dev_addr,
    input  logic [8*N_REQ-1:0]   req_reg_addr,
    input  logic [N_REQ-1:0]     req_rw,
    input  logic [8*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic [7:0]           rdata,
    output logic                 err,
    output logic                 m_start,
    output logic [6:0]           m_dev_addr,
    output logic [7:0]           m_reg_addr,
    output logic                 m_rw,
    output logic [7:0]           m_wdata,
    output logic                 m_abort,
    input  logic                 m_busy,
    input  logic                 m_done,
    input  logic                 m_ack_err,
    input  logic [7:0]           m_rdata,
    output logic                 busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        COMPLETE
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               m_start_q, m_start_d;
    logic               m_abort_q, m_abort_d;
    logic [6:0]         m_dev_addr_q, m_dev_addr_d;
    logic [7:0]         m_reg_addr_q, m_reg_addr_d;
    logic               m_rw_q, m_rw_d;
    logic [7:0]         m_wdata_q, m_wdata_d;
    logic               busy_q;

    logic [PTR_W-1:0]   scan_idx;
    logic [PTR_W-1:0]   win_idx;
    logic               timeout_hit;

    logic [6:0]         dev_arr   [N_REQ];
    logic [7:0]         reg_arr   [N_REQ];
    logic [7:0]         wdata_arr [N_REQ];

    // m_busy is informational only; sequencing relies on m_done and the timeout.
    logic               unused_m_busy;
    assign unused_m_busy = m_busy;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign dev_arr[g]   = req_dev_addr[7*g +: 7];
        assign reg_arr[g]   = req_reg_addr[8*g +: 8];
        assign wdata_arr[g] = req_wdata[8*g +: 8];
    end

    // Round-robin search: scan offsets from the highest down to zero so the
    // last hit written is the requester closest at-or-after the pointer.
    always_comb begin
        win_idx  = '0;
        scan_idx = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            scan_idx = PTR_W'((int'(ptr_q) + off) % N_REQ);
            if (req[scan_idx]) begin
                win_idx = scan_idx;
            end
        end
    end

    // The counter is compared against TIMEOUT_CYCLES-2 because it is bumped on
    // the same edge that registers m_abort, so the visible count reads
    // TIMEOUT_CYCLES-1 exactly when the abort strobe appears, TIMEOUT_CYCLES
    // cycles after m_start.
    assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 2));

    // Next-state and registered-output logic. Strobes default low; everything
    // else holds unless the current state changes it.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        to_cnt_d     = to_cnt_q;
        grant_d      = grant_q;
        done_d       = '0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        m_start_d    = 1'b0;
        m_abort_d    = 1'b0;
        m_dev_addr_d = m_dev_addr_q;
        m_reg_addr_d = m_reg_addr_q;
        m_rw_d       = m_rw_q;
        m_wdata_d    = m_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d      = win_idx;
                    grant_d      = N_REQ'(1) << win_idx;
                    m_dev_addr_d = dev_arr[win_idx];
                    m_reg_addr_d = reg_arr[win_idx];
                    m_rw_d       = req_rw[win_idx];
                    m_wdata_d    = wdata_arr[win_idx];
                    m_start_d    = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                to_cnt_d = '0;
                state_d  = WAIT_DONE;
            end
            WAIT_DONE: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (m_done) begin
                    rdata_d = m_rdata;
                    err_d   = m_ack_err;
                    done_d  = grant_q;
                    state_d = COMPLETE;
                end else if (timeout_hit) begin
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    m_abort_d = 1'b1;
                    done_d    = grant_q;
                    state_d   = COMPLETE;
                end
            end
            COMPLETE: begin
                grant_d = '0;
                ptr_d   = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; busy is registered from the next state so it
    // tracks the state register without a decode after the flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            to_cnt_q     <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            m_start_q    <= 1'b0;
            m_abort_q    <= 1'b0;
            m_dev_addr_q <= '0;
            m_reg_addr_q <= '0;
            m_rw_q       <= 1'b0;
            m_wdata_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            to_cnt_q     <= to_cnt_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            m_start_q    <= m_start_d;
            m_abort_q    <= m_abort_d;
            m_dev_addr_q <= m_dev_addr_d;
            m_reg_addr_q <= m_reg_addr_d;
            m_rw_q       <= m_rw_d;
            m_wdata_q    <= m_wdata_d;
            busy_q       <= (state_d != IDLE);
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign rdata      = rdata_q;
    assign err        = err_q;
    assign m_start    = m_start_q;
    assign m_abort    = m_abort_q;
    assign m_dev_addr = m_dev_addr_q;
    assign m_reg_addr = m_reg_addr_q;
    assign m_rw       = m_rw_q;
    assign m_wdata    = m_wdata_q;
    assign busy       = busy_q;

endmodule
